bcast_fanout_stage: RTL

BCAST_FANOUT_STAGE -- requirements
Module: bcast_fanout_stage

---
 rtl/bcast_fanout_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bcast_fanout_stage.sv
// ---------------------------------------------------------------------------
// bcast_fanout_stage
//
// Purpose:
//   Broadcast stage. Each accepted payload is delivered exactly once to every
//   load selected by load_en. Loads accept independently and in any order.
//   When the last selected load has taken the head, the head retires at that
//   edge and done_cnt increments. A 2-entry FIFO decouples upstream from
//   slow loads. A queued second entry is promoted to head without a bubble.
//
// Ports:
//   clk        : rising-edge clock for all state
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream payload valid
//   in_ready   : stage can take a payload this cycle (count < 2)
//   in_data    : upstream payload, WIDTH bits
//   load_en    : per-load delivery mask, sampled whenever a head is armed
//   out_valid  : per-load valid, equal to the outstanding-delivery mask
//   out_ready  : per-load accept
//   out_data   : head payload shared by all loads (holds last head in IDLE)
//   done_cnt   : number of completed broadcasts, wraps at 16 bits
// ---------------------------------------------------------------------------
module bcast_fanout_stage #(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [NUM_LOADS-1:0] load_en,
    output logic [NUM_LOADS-1:0] out_valid,
    input  logic [NUM_LOADS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [15:0]          done_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             count_q, count_d;
    logic [NUM_LOADS-1:0]   pend_q, pend_d;
    logic [WIDTH-1:0]       head_q, head_d;   // FIFO head, also drives out_data
    logic [WIDTH-1:0]       tail_q, tail_d;   // second FIFO entry (valid when count = 2)
    logic [15:0]            done_cnt_q, done_cnt_d;

    logic [NUM_LOADS-1:0]   deliver;
    logic [NUM_LOADS-1:0]   pend_left;        // deliveries still owed after this edge
    logic                   push;
    logic                   pop;

    // in_ready comes only from the registered count. It never looks at
    // in_valid or out_ready. A full FIFO therefore refuses a push even in a
    // cycle that pops.
    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid & in_ready;

    // out_valid is a pure function of registered state.
    assign out_valid = (state_q == BCAST) ? pend_q : '0;
    assign out_data  = head_q;
    assign done_cnt  = done_cnt_q;

    assign deliver   = out_valid & out_ready;

    generate
        for (genvar gi = 0; gi < NUM_LOADS; gi++) begin : g_pend
            assign pend_left[gi] = pend_q[gi] & ~deliver[gi];
        end
    endgenerate

    // The head retires once nothing remains outstanding after this cycle's
    // deliveries. An all-zero mask therefore retires after one BCAST cycle.
    assign pop = (state_q == BCAST) && (pend_left == '0);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pend_d     = pend_left;
        head_d     = head_q;
        tail_d     = tail_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = BCAST;
                    count_d = 2'd1;
                    head_d  = in_data;
                    pend_d  = load_en;
                end
            end
            BCAST: begin
                if (pop) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    if (count_q == 2'd2) begin
                        // Promote the queued entry. No push is possible here
                        // because in_ready is low.
                        head_d  = tail_q;
                        pend_d  = load_en;
                        count_d = 2'd1;
                    end else if (push) begin
                        // The pushed payload bypasses the tail slot.
                        head_d  = in_data;
                        pend_d  = load_en;
                        count_d = 2'd1;
                    end else begin
                        state_d = IDLE;
                        count_d = 2'd0;
                        pend_d  = '0;
                    end
                end else if (push) begin
                    tail_d  = in_data;
                    count_d = 2'd2;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 2'd0;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= 2'd0;
            pend_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            done_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule
